tlb_maint_ctrl: RTL and testbench
=================================

TLB_MAINT_CTRL -- requirements
Module: tlb_maint_ctrl

Interface
REQ-001 The block SHALL have one clock; reset SHALL be asynchronous and active-high, ports named clk and reset.
REQ-002 Parameters (name, default, meaning):
- TLBNUM, 16, TLB entry count, power of 2, range 4..64.
- IDXW, log2(TLBNUM), index width, derived.
- FILL_MODE, 0, TLBFILL index policy: 0 round-robin, 1 LFSR.
- LFSR_SEED, 16'hACE1, LFSR reset value, nonzero.
REQ-003 Ports (name, direction, width, meaning):
- clk  in  1  clock.
- reset  in  1  async active-high reset.
- op_valid  in  1  WB holds a valid TLB instruction.
- op  in  5  one-hot {[4]tlbsrch,[3]tlbrd,[2]tlbwr,[1]tlbfill,[0]invtlb}.
- inv_op  in  5  INVTLB op code.
- inv_asid  in  10  INVTLB asid operand.
- inv_vppn  in  19  INVTLB va[31:13].
- op_flush  in  1  cancel current op (WB flush).
- csr_tlbidx_index  in  IDXW  TLBIDX.index.
- r_index  out  IDXW  TLB read port index.
- r_e, r_g  in  1 each  read-entry E, G.
- r_asid  in  10  read-entry ASID.
- r_vppn  in  19  read-entry VPPN.
- r_ps  in  6  read-entry page size.
- we  out  1  TLB write strobe.
- w_index  out  IDXW  write index.
- inv_we  out  1  clear E of entry inv_index.
- inv_index  out  IDXW  entry to invalidate.
- busy  out  1  INVTLB sweep in progress.
- op_done  out  1  op completes this cycle; WB ready_go.

Function
REQ-004 States SHALL be IDLE and SWEEP; reset state IDLE.
REQ-005 IDLE, op_valid with op[4], op[3], op[2] or op[1]: op_done=1 in the same cycle, combinationally.
REQ-006 IDLE tlbrd: r_index SHALL equal csr_tlbidx_index.
REQ-007 we SHALL equal op_valid & (op[2]|op[1]) & ~op_flush & IDLE.
REQ-008 tlbwr: w_index SHALL equal csr_tlbidx_index.
REQ-009 tlbfill: w_index SHALL equal fill_ptr when FILL_MODE=0, and lfsr[IDXW-1:0] when FILL_MODE=1.
REQ-010 fill_ptr SHALL increment by 1 only on a cycle with we & op[1], wrapping TLBNUM-1 to 0.
REQ-011 LFSR SHALL be a 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11+1, stepping every cycle regardless of ops.
REQ-012 IDLE, op_valid & op[0] & ~op_flush with inv_op<=6: latch inv_op, inv_asid and inv_vppn, set sweep counter to 0, enter SWEEP next cycle; op_done=0.
REQ-013 IDLE, op[0] with inv_op>=7: op_done=1 same cycle, no SWEEP, no inv_we.
REQ-014 SWEEP: r_index=inv_index=counter; busy=1; counter +1 per cycle.
REQ-015 SWEEP inv_we=1 when the latched op matches the entry read that cycle:
- op 0/1: always.
- op 2: r_g=1.
- op 3: r_g=0.
- op 4: r_g=0 & asid equal.
- op 5: r_g=0 & asid equal & va match.
- op 6: (r_g=1 | asid equal) & va match.
REQ-016 va match SHALL compare r_vppn[18:10] when r_ps=21, and the full 19 bits otherwise.
REQ-017 In SWEEP, counter=TLBNUM-1: op_done=1 and return to IDLE next cycle; total latency TLBNUM+1 cycles from acceptance.
REQ-018 op_flush in SWEEP: inv_we=0 that cycle, return to IDLE next cycle, op_done=0; entries already cleared stay cleared.
REQ-019 op_valid=0 in SWEEP SHALL be treated as op_flush.
REQ-020 op_flush in IDLE: we=0, inv_we=0, no state change, fill_ptr held.
REQ-021 In SWEEP, we SHALL be 0 and any non-invtlb op SHALL be ignored.

Reset
REQ-022 Reset values:
- state=IDLE, counter=0, fill_ptr=0, lfsr=LFSR_SEED.
- we, inv_we, busy and op_done all 0.
- r_index, w_index and inv_index all 0.
REQ-023 Reset mid-SWEEP SHALL abort immediately with no further inv_we.

Verification
REQ-024 FILL_MODE=0, TLBNUM=16, 17 consecutive tlbfill -> w_index 0..15 then 0, we=1 each cycle.
REQ-025 TLBNUM=16, invtlb op 0 -> busy for 16 cycles, inv_we=1 for inv_index 0..15, op_done only on index 15.
REQ-026 Invtlb op 5, asid=3, vppn=0x12345, entry 7 {g=0,asid=3,vppn=0x12345,ps=12}, entry 9 same but asid=4 -> inv_we only at index 7.
REQ-027 Invtlb op 6, entry 2 {g=1,ps=21,vppn=0x12000}, inv_vppn=0x123FF -> inv_we at index 2.
REQ-028 op_flush at sweep index 5 of op 0 -> inv_we for 0..4 only, IDLE next cycle, no op_done.
REQ-029 FILL_MODE=1, tlbwr with csr index 3 then tlbfill -> w_index 3, then w_index = lfsr[3:0] of that cycle; reset -> lfsr=0xACE1.

Source files
------------

// File: rtl/tlb_maint_ctrl.sv
// rtl/tlb_maint_ctrl.sv - TLB maintenance controller: single-cycle TLBSRCH/RD/WR/FILL
// handshakes and a multi-cycle INVTLB sweep over every entry.
module tlb_maint_ctrl #(
  parameter int          TLBNUM    = 16,
  parameter int          IDXW      = $clog2(TLBNUM),
  parameter int          FILL_MODE = 0,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            op_valid,
  input  logic [4:0]      op,
  input  logic [4:0]      inv_op,
  input  logic [9:0]      inv_asid,
  input  logic [18:0]     inv_vppn,
  input  logic            op_flush,
  input  logic [IDXW-1:0] csr_tlbidx_index,
  output logic [IDXW-1:0] r_index,
  input  logic            r_e,
  input  logic            r_g,
  input  logic [9:0]      r_asid,
  input  logic [18:0]     r_vppn,
  input  logic [5:0]      r_ps,
  output logic            we,
  output logic [IDXW-1:0] w_index,
  output logic            inv_we,
  output logic [IDXW-1:0] inv_index,
  output logic            busy,
  output logic            op_done
);

  typedef enum logic {IDLE = 1'b0, SWEEP = 1'b1} state_e;

  state_e          state_q, state_d;
  logic [IDXW-1:0] cnt_q, cnt_d;
  logic [IDXW-1:0] fill_ptr_q, fill_ptr_d;
  logic [15:0]     lfsr_q, lfsr_d;
  logic [4:0]      inv_op_q, inv_op_d;
  logic [9:0]      inv_asid_q, inv_asid_d;
  logic [18:0]     inv_vppn_q, inv_vppn_d;

  logic            accept, abort, last, fill_we;
  logic            asid_eq, va_match, entry_hit;
  logic [IDXW-1:0] fill_idx;
  logic            unused_r_e;

  assign unused_r_e = r_e;

  // A dropped op_valid during the sweep means WB moved on, so it aborts like a flush.
  assign abort   = op_flush | ~op_valid;
  assign last    = (cnt_q == IDXW'(TLBNUM - 1));
  assign accept  = (state_q == IDLE) & op_valid & op[0] & ~op_flush & (inv_op <= 5'd6);
  assign fill_we = (state_q == IDLE) & op_valid & op[1] & ~op_flush;
  assign fill_idx = (FILL_MODE == 1) ? lfsr_q[IDXW-1:0] : fill_ptr_q;

  // Huge (2MB, ps=21) pages only compare the upper 9 VPPN bits.
  assign asid_eq  = (r_asid == inv_asid_q);
  assign va_match = (r_ps == 6'd21) ? (r_vppn[18:10] == inv_vppn_q[18:10])
                                    : (r_vppn == inv_vppn_q);

  always_comb begin
    case (inv_op_q)
      5'd0, 5'd1: entry_hit = 1'b1;
      5'd2:       entry_hit = r_g;
      5'd3:       entry_hit = ~r_g;
      5'd4:       entry_hit = ~r_g & asid_eq;
      5'd5:       entry_hit = ~r_g & asid_eq & va_match;
      5'd6:       entry_hit = (r_g | asid_eq) & va_match;
      default:    entry_hit = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SWEEP;
      SWEEP:   if (abort || last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    r_index   = '0;
    w_index   = '0;
    inv_index = '0;
    we        = 1'b0;
    inv_we    = 1'b0;
    busy      = 1'b0;
    op_done   = 1'b0;
    if (!reset) begin
      case (state_q)
        IDLE: begin
          op_done = op_valid & ((|op[4:1]) | (op[0] & (inv_op > 5'd6)));
          we      = op_valid & (op[2] | op[1]) & ~op_flush;
          if (op_valid & op[3]) r_index = csr_tlbidx_index;
          if (op[2])      w_index = csr_tlbidx_index;
          else if (op[1]) w_index = fill_idx;
        end
        SWEEP: begin
          busy      = 1'b1;
          r_index   = cnt_q;
          inv_index = cnt_q;
          inv_we    = ~abort & entry_hit;
          op_done   = ~abort & last;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    cnt_d      = cnt_q;
    fill_ptr_d = fill_ptr_q;
    inv_op_d   = inv_op_q;
    inv_asid_d = inv_asid_q;
    inv_vppn_d = inv_vppn_q;
    lfsr_d     = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    if (accept) begin
      cnt_d      = '0;
      inv_op_d   = inv_op;
      inv_asid_d = inv_asid;
      inv_vppn_d = inv_vppn;
    end else if (state_q == SWEEP) begin
      cnt_d = cnt_q + IDXW'(1);
    end
    if (fill_we) fill_ptr_d = fill_ptr_q + IDXW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q      <= '0;
      fill_ptr_q <= '0;
      lfsr_q     <= LFSR_SEED;
      inv_op_q   <= '0;
      inv_asid_q <= '0;
      inv_vppn_q <= '0;
    end else begin
      cnt_q      <= cnt_d;
      fill_ptr_q <= fill_ptr_d;
      lfsr_q     <= lfsr_d;
      inv_op_q   <= inv_op_d;
      inv_asid_q <= inv_asid_d;
      inv_vppn_q <= inv_vppn_d;
    end
  end

endmodule

// File: tb/tb_tlb_maint_ctrl.sv
// tb/tb_tlb_maint_ctrl.sv - scoreboard bench for tlb_maint_ctrl (round-robin and LFSR fill instances).
module tb_tlb_maint_ctrl;
  localparam int TLBNUM = 16;
  localparam int IDXW   = 4;
  localparam logic [4:0] OP_SRCH = 5'b10000, OP_RD = 5'b01000, OP_WR = 5'b00100,
                         OP_FILL = 5'b00010, OP_INV = 5'b00001;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic            op_valid = 1'b0, op_flush = 1'b0;
  logic [4:0]      op = '0, inv_op = '0;
  logic [9:0]      inv_asid = '0;
  logic [18:0]     inv_vppn = '0;
  logic [IDXW-1:0] csr_idx = '0;
  logic            r_e, r_g;
  logic [9:0]      r_asid;
  logic [18:0]     r_vppn;
  logic [5:0]      r_ps;

  logic [IDXW-1:0] d0_r_index, d0_w_index, d0_inv_index, d1_r_index, d1_w_index, d1_inv_index;
  logic            d0_we, d0_inv_we, d0_busy, d0_op_done, d1_we, d1_inv_we, d1_busy, d1_op_done;

  logic            tlb_g[TLBNUM];
  logic [9:0]      tlb_asid[TLBNUM];
  logic [18:0]     tlb_vppn[TLBNUM];
  logic [5:0]      tlb_ps[TLBNUM];

  assign r_e    = 1'b1;
  assign r_g    = tlb_g[d0_r_index];
  assign r_asid = tlb_asid[d0_r_index];
  assign r_vppn = tlb_vppn[d0_r_index];
  assign r_ps   = tlb_ps[d0_r_index];

  tlb_maint_ctrl #(.TLBNUM(TLBNUM), .FILL_MODE(0)) dut0 (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op(op), .inv_op(inv_op),
    .inv_asid(inv_asid), .inv_vppn(inv_vppn), .op_flush(op_flush), .csr_tlbidx_index(csr_idx),
    .r_index(d0_r_index), .r_e(r_e), .r_g(r_g), .r_asid(r_asid), .r_vppn(r_vppn), .r_ps(r_ps),
    .we(d0_we), .w_index(d0_w_index), .inv_we(d0_inv_we), .inv_index(d0_inv_index),
    .busy(d0_busy), .op_done(d0_op_done));

  tlb_maint_ctrl #(.TLBNUM(TLBNUM), .FILL_MODE(1)) dut1 (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op(op), .inv_op(inv_op),
    .inv_asid(inv_asid), .inv_vppn(inv_vppn), .op_flush(op_flush), .csr_tlbidx_index(csr_idx),
    .r_index(d1_r_index), .r_e(r_e), .r_g(r_g), .r_asid(r_asid), .r_vppn(r_vppn), .r_ps(r_ps),
    .we(d1_we), .w_index(d1_w_index), .inv_we(d1_inv_we), .inv_index(d1_inv_index),
    .busy(d1_busy), .op_done(d1_op_done));

  int checks = 0;
  int errors = 0;
  int exp_w0[$];
  int exp_w1[$];
  int exp_inv[$];
  int exp_done[$];
  int busy_cnt = 0;
  int fptr = 0;
  logic [15:0] lfsr_m;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  always @(posedge clk) lfsr_m <= reset ? 16'hACE1 : lfsr_next(lfsr_m);

  // Scoreboard side: every strobe seen must match the head of its expectation queue.
  always @(negedge clk) begin
    if (!reset) begin
      if (d0_we) begin
        if (exp_w0.size() == 0) check("we0_unexpected", d0_w_index, 32'hdead);
        else check("w_index0", d0_w_index, exp_w0.pop_front());
      end
      if (d1_we) begin
        if (exp_w1.size() == 0) check("we1_unexpected", d1_w_index, 32'hdead);
        else check("w_index1", d1_w_index, exp_w1.pop_front());
      end
      if (d0_inv_we) begin
        if (exp_inv.size() == 0) check("inv_we_unexpected", d0_inv_index, 32'hdead);
        else check("inv_index", d0_inv_index, exp_inv.pop_front());
      end
      if (d0_op_done) begin
        if (exp_done.size() == 0) check("op_done_unexpected", {d0_busy, d0_inv_index}, 32'hdead);
        else check("op_done_ctx", {d0_busy, d0_inv_index}, exp_done.pop_front());
      end
      if (d0_busy) busy_cnt++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    op_valid = 1'b0; op = '0; op_flush = 1'b0;
  endtask

  task automatic drain(input string tag);
    step(); step();
    check({tag, "_w0_left"}, exp_w0.size(), 0);
    check({tag, "_w1_left"}, exp_w1.size(), 0);
    check({tag, "_inv_left"}, exp_inv.size(), 0);
    check({tag, "_done_left"}, exp_done.size(), 0);
  endtask

  task automatic drive_fill(input logic flush);
    op_valid = 1'b1; op = OP_FILL; op_flush = flush;
    exp_done.push_back(0);
    if (!flush) begin
      exp_w0.push_back(fptr);
      exp_w1.push_back(int'(lfsr_m[3:0]));
      fptr = (fptr + 1) % TLBNUM;
    end
  endtask

  task automatic set_entry(input int i, input logic g, input logic [9:0] a,
                           input logic [18:0] v, input logic [5:0] ps);
    tlb_g[i] = g; tlb_asid[i] = a; tlb_vppn[i] = v; tlb_ps[i] = ps;
  endtask

  task automatic run_inv(input logic [4:0] iop, input logic [9:0] a, input logic [18:0] v,
                         input int stop_at, input bit drop_valid);
    busy_cnt = 0;
    op_valid = 1'b1; op = OP_INV; inv_op = iop; inv_asid = a; inv_vppn = v; op_flush = 1'b0;
    for (int k = 0; k < TLBNUM; k++) begin
      step();
      if (k == stop_at) begin
        if (drop_valid) op_valid = 1'b0;
        else op_flush = 1'b1;
        step();
        idle();
        return;
      end
    end
    step();
    idle();
  endtask

  initial begin
    for (int i = 0; i < TLBNUM; i++) set_entry(i, 1'b0, 10'd0, 19'd0, 6'd12);
    op_valid = 1'b1; op = OP_WR; csr_idx = 4'd5;
    repeat (3) @(posedge clk);
    #1;
    check("rst_we", d0_we, 0);
    check("rst_w_index", d0_w_index, 0);
    check("rst_inv_we", d0_inv_we, 0);
    check("rst_busy", d0_busy, 0);
    check("rst_op_done", d0_op_done, 0);
    check("rst_r_index", d0_r_index, 0);
    check("rst_inv_index", d0_inv_index, 0);

    // 17 back-to-back fills right out of reset; first LFSR index is the seed's low nibble.
    reset = 1'b0;
    op_valid = 1'b1; op = OP_FILL;
    exp_w0.push_back(0); exp_w1.push_back(1); exp_done.push_back(0); fptr = 1;
    for (int i = 1; i < 17; i++) begin
      step();
      drive_fill(1'b0);
    end
    step(); idle();
    drain("fill17");

    op_valid = 1'b1; op = OP_WR; csr_idx = 4'd3;
    exp_w0.push_back(3); exp_w1.push_back(3); exp_done.push_back(0);
    step();
    drive_fill(1'b0);
    step();
    drive_fill(1'b1);
    step();
    drive_fill(1'b0);
    step(); idle();
    drain("wr_fill");

    op_valid = 1'b1; op = OP_RD; csr_idx = 4'd9; exp_done.push_back(0);
    @(negedge clk);
    check("tlbrd_r_index", d0_r_index, 9);
    step();
    op = OP_SRCH; exp_done.push_back(0);
    step();
    op = OP_INV; inv_op = 5'd7; exp_done.push_back(0); busy_cnt = 0;
    step(); idle();
    drain("srch_inv7");
    check("inv7_no_busy", busy_cnt, 0);

    for (int i = 0; i < TLBNUM; i++) exp_inv.push_back(i);
    exp_done.push_back(32'h1F);
    run_inv(5'd0, 10'd0, 19'd0, -1, 1'b0);
    drain("inv0");
    check("inv0_busy_cycles", busy_cnt, 16);

    for (int i = 0; i < TLBNUM; i++) set_entry(i, 1'b1, 10'd3, 19'h12345, 6'd12);
    set_entry(7, 1'b0, 10'd3, 19'h12345, 6'd12);
    set_entry(9, 1'b0, 10'd4, 19'h12345, 6'd12);
    exp_inv.push_back(7); exp_done.push_back(32'h1F);
    run_inv(5'd5, 10'd3, 19'h12345, -1, 1'b0);
    drain("inv5");

    for (int i = 0; i < TLBNUM; i++) set_entry(i, 1'b0, 10'd5, 19'h123FF, 6'd12);
    set_entry(2, 1'b1, 10'd9, 19'h12000, 6'd21);
    set_entry(4, 1'b1, 10'd9, 19'h12000, 6'd12);
    set_entry(6, 1'b0, 10'd3, 19'h123FF, 6'd12);
    exp_inv.push_back(2); exp_inv.push_back(6); exp_done.push_back(32'h1F);
    run_inv(5'd6, 10'd3, 19'h123FF, -1, 1'b0);
    drain("inv6");

    for (int i = 0; i < TLBNUM; i++) if (!tlb_g[i]) exp_inv.push_back(i);
    exp_done.push_back(32'h1F);
    run_inv(5'd3, 10'd0, 19'd0, -1, 1'b0);
    drain("inv3");

    for (int i = 0; i < 5; i++) exp_inv.push_back(i);
    run_inv(5'd0, 10'd0, 19'd0, 5, 1'b0);
    @(negedge clk);
    check("flush_back_idle", d0_busy, 0);
    drain("inv_flush");
    check("flush_busy_cycles", busy_cnt, 6);

    for (int i = 0; i < 3; i++) exp_inv.push_back(i);
    run_inv(5'd1, 10'd0, 19'd0, 3, 1'b1);
    drain("inv_drop_valid");

    for (int i = 0; i < 3; i++) exp_inv.push_back(i);
    op_valid = 1'b1; op = OP_INV; inv_op = 5'd0; op_flush = 1'b0;
    repeat (4) step();
    reset = 1'b1;
    @(negedge clk);
    check("midsweep_rst_inv_we", d0_inv_we, 0);
    check("midsweep_rst_busy", d0_busy, 0);
    idle();
    step(); step();
    reset = 1'b0;
    op_valid = 1'b1; op = OP_FILL;
    exp_w0.push_back(0); exp_w1.push_back(1); exp_done.push_back(0); fptr = 1;
    step(); idle();
    drain("post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
